// File: rtl/sudoku_loader.sv
// Clears the 9x9 grid and its row/col/box mark arrays, then streams a raster-order puzzle into them.
// Define SUDOKU_LOADER_CONFLICT_CHECK_EN to add duplicate-given detection and o_conflict_idx.
module sudoku_loader #(
  parameter int N_CELL      = 81,
  parameter int MARK_STRIDE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [3:0] i_digit,
  output logic       o_ready,
  output logic       o_we,
  output logic [3:0] o_wrdata,
  output logic [6:0] o_addr,
  output logic       o_we_mark,
  output logic       o_wrdata_mark_row,
  output logic       o_wrdata_mark_col,
  output logic       o_wrdata_mark_matrix,
  output logic [6:0] o_addr_mark_row,
  output logic [6:0] o_addr_mark_col,
  output logic [6:0] o_addr_mark_matrix,
  output logic       o_busy,
  output logic       o_done,
  output logic [6:0] o_given_cnt,
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
  output logic       o_error,
  output logic [6:0] o_conflict_idx
`else
  output logic       o_error
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [6:0] k;
  logic [3:0] row, col;

  logic       start_p0, acc_p0, given_p0, bad_p0, last_p0, err_hit_p0;
  logic [6:0] idx_p0;
  logic [3:0] box_p0;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 7'(r) * 7'(MARK_STRIDE) + 7'(c);
  endfunction

  function automatic logic [3:0] box_of(input logic [3:0] r, input logic [3:0] c);
    return (r / 4'd3) * 4'd3 + c / 4'd3;
  endfunction

  function automatic logic [6:0] mark_addr(input logic [3:0] grp, input logic [3:0] d);
    return 7'(grp) * 7'(MARK_STRIDE) + 7'(d) - 7'd1;
  endfunction

  assign start_p0 = (state == S_IDLE) && i_start;
  assign acc_p0   = i_valid && o_ready;
  assign idx_p0   = cell_idx(row, col);
  assign box_p0   = box_of(row, col);
  assign given_p0 = (i_digit != 4'd0) && (i_digit <= 4'd9);
  assign bad_p0   = (i_digit > 4'd9);
  assign last_p0  = (idx_p0 == 7'(N_CELL - 1));

  assign o_ready = (state == S_LOAD);
  assign o_busy  = (state == S_CLEAR) || (state == S_LOAD);
  assign o_done  = (state == S_DONE);

`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
  logic [8:0] row_bm [9];
  logic [8:0] col_bm [9];
  logic [8:0] box_bm [9];
  logic [8:0] dig_onehot_p0;
  logic       dup_p0;
  logic       conflict_seen;

  assign dig_onehot_p0 = given_p0 ? (9'd1 << (i_digit - 4'd1)) : 9'd0;
  assign dup_p0        = |((row_bm[row] | col_bm[col] | box_bm[box_p0]) & dig_onehot_p0);
  assign err_hit_p0    = bad_p0 || dup_p0;

  // Shadow bitmaps only need a clean slate per puzzle, so they clear on start rather than reset
  always_ff @(posedge clk) begin
    if (start_p0) begin
      for (int i = 0; i < 9; i++) begin
        row_bm[i] <= '0;
        col_bm[i] <= '0;
        box_bm[i] <= '0;
      end
    end else if ((state == S_LOAD) && acc_p0 && given_p0) begin
      row_bm[row]    <= row_bm[row] | dig_onehot_p0;
      col_bm[col]    <= col_bm[col] | dig_onehot_p0;
      box_bm[box_p0] <= box_bm[box_p0] | dig_onehot_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_conflict_idx <= '0;
      conflict_seen  <= 1'b0;
    end else if (start_p0) begin
      o_conflict_idx <= '0;
      conflict_seen  <= 1'b0;
    end else if ((state == S_LOAD) && acc_p0 && dup_p0 && !conflict_seen) begin
      o_conflict_idx <= idx_p0;
      conflict_seen  <= 1'b1;
    end
  end
`else
  assign err_hit_p0 = bad_p0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_CLEAR;
      S_CLEAR: if (k == 7'(N_CELL - 1)) state_nxt = S_LOAD;
      S_LOAD:  if (acc_p0 && last_p0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters and status
  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      row         <= '0;
      col         <= '0;
      o_given_cnt <= '0;
      o_error     <= 1'b0;
    end else if (start_p0) begin
      k           <= '0;
      row         <= '0;
      col         <= '0;
      o_given_cnt <= '0;
      o_error     <= 1'b0;
    end else if (state == S_CLEAR) begin
      k <= k + 7'd1;
      if (k == 7'(N_CELL - 1)) begin
        row <= '0;
        col <= '0;
      end
    end else if ((state == S_LOAD) && acc_p0) begin
      if (last_p0) begin
        row <= '0;
        col <= '0;
      end else if (col == 4'd8) begin
        col <= '0;
        row <= row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
      if (given_p0)   o_given_cnt <= o_given_cnt + 7'd1;
      if (err_hit_p0) o_error     <= 1'b1;
    end
  end

  // Memory write port: one registered stage behind the clear counter / accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      o_we                 <= 1'b0;
      o_wrdata             <= '0;
      o_addr               <= '0;
      o_we_mark            <= 1'b0;
      o_wrdata_mark_row    <= 1'b0;
      o_wrdata_mark_col    <= 1'b0;
      o_wrdata_mark_matrix <= 1'b0;
      o_addr_mark_row      <= '0;
      o_addr_mark_col      <= '0;
      o_addr_mark_matrix   <= '0;
    end else begin
      o_we      <= 1'b0;
      o_we_mark <= 1'b0;
      if (state == S_CLEAR) begin
        o_we                 <= 1'b1;
        o_addr               <= k;
        o_wrdata             <= '0;
        o_we_mark            <= 1'b1;
        o_addr_mark_row      <= k;
        o_addr_mark_col      <= k;
        o_addr_mark_matrix   <= k;
        o_wrdata_mark_row    <= 1'b0;
        o_wrdata_mark_col    <= 1'b0;
        o_wrdata_mark_matrix <= 1'b0;
      end else if ((state == S_LOAD) && acc_p0) begin
        o_we     <= 1'b1;
        o_addr   <= idx_p0;
        o_wrdata <= given_p0 ? i_digit : 4'd0;
        if (given_p0) begin
          o_we_mark            <= 1'b1;
          o_addr_mark_row      <= mark_addr(row, i_digit);
          o_addr_mark_col      <= mark_addr(col, i_digit);
          o_addr_mark_matrix   <= mark_addr(box_p0, i_digit);
          o_wrdata_mark_row    <= 1'b1;
          o_wrdata_mark_col    <= 1'b1;
          o_wrdata_mark_matrix <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_loader.sv
// Directed bench for sudoku_loader: clear, givens, back-pressure, bad digit, mid-load reset, conflicts.
module tb_sudoku_loader;
  localparam int N = 81;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_start, i_valid;
  logic [3:0] i_digit;
  logic       o_ready, o_we, o_we_mark, o_busy, o_done, o_error;
  logic [3:0] o_wrdata;
  logic [6:0] o_addr, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix, o_given_cnt;
  logic       o_wrdata_mark_row, o_wrdata_mark_col, o_wrdata_mark_matrix;
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
  logic [6:0] o_conflict_idx;
`endif

  sudoku_loader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_digit(i_digit),
    .o_ready(o_ready), .o_we(o_we), .o_wrdata(o_wrdata), .o_addr(o_addr),
    .o_we_mark(o_we_mark), .o_wrdata_mark_row(o_wrdata_mark_row),
    .o_wrdata_mark_col(o_wrdata_mark_col), .o_wrdata_mark_matrix(o_wrdata_mark_matrix),
    .o_addr_mark_row(o_addr_mark_row), .o_addr_mark_col(o_addr_mark_col),
    .o_addr_mark_matrix(o_addr_mark_matrix), .o_busy(o_busy), .o_done(o_done),
    .o_given_cnt(o_given_cnt),
    .o_error(o_error)
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
    , .o_conflict_idx(o_conflict_idx)
`endif
  );

  typedef struct packed {
    logic [6:0] a;
    logic [3:0] d;
    logic       m;
    logic [6:0] ar;
    logic [6:0] ac;
    logic [6:0] am;
    logic [2:0] md;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  wq[$];
  wr_t  rec_w;
  int   done_cnt, busy_cnt;
  bit   rec_en = 1'b0;
  logic [3:0] grid [N];

  // Write-bus recorder; mark fields are only meaningful when the mark strobe is up
  always @(negedge clk) begin
    if (rec_en) begin
      if (o_we || o_we_mark) begin
        rec_w   = '0;
        rec_w.a = o_addr;
        rec_w.d = o_wrdata;
        rec_w.m = o_we_mark;
        if (o_we_mark) begin
          rec_w.ar = o_addr_mark_row;
          rec_w.ac = o_addr_mark_col;
          rec_w.am = o_addr_mark_matrix;
          rec_w.md = {o_wrdata_mark_row, o_wrdata_mark_col, o_wrdata_mark_matrix};
        end
        wq.push_back(rec_w);
      end
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
    end
  end

  function automatic wr_t exp_clear(input int k);
    wr_t e;
    e    = '0;
    e.a  = 7'(k);
    e.m  = 1'b1;
    e.ar = 7'(k);
    e.ac = 7'(k);
    e.am = 7'(k);
    return e;
  endfunction

  function automatic wr_t exp_load(input int i, input logic [3:0] d);
    wr_t e;
    int  r, c, b, dv;
    r  = i / 9;
    c  = i % 9;
    b  = (r / 3) * 3 + c / 3;
    dv = int'(d);
    e  = '0;
    e.a = 7'(i);
    if (dv >= 1 && dv <= 9) begin
      e.d  = d;
      e.m  = 1'b1;
      e.ar = 7'(r * 9 + dv - 1);
      e.ac = 7'(c * 9 + dv - 1);
      e.am = 7'(b * 9 + dv - 1);
      e.md = 3'b111;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_grid();
    for (int i = 0; i < N; i++) grid[i] = 4'd0;
  endtask

  task automatic run_grid(input bit bp, input int stop_at);
    int idx, cyc;
    bit v, acc;
    wq.delete();
    done_cnt = 0;
    busy_cnt = 0;
    rec_en   = 1'b1;
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 3000) begin
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = v;
      i_digit = grid[idx];
      @(negedge clk);
      acc = v && o_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    i_valid = 1'b0;
    i_digit = 4'd0;
    total++;
    if (idx != stop_at) begin
      bad++;
      $display("FAIL accept_budget: accepted=%0d required=%0d", idx, stop_at);
    end
    if (stop_at == N) repeat (3) tick();
    rec_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_digit = 4'd0;
    repeat (2) tick();
    total++;
    if ({o_ready, o_we, o_wrdata, o_addr, o_we_mark, o_wrdata_mark_row, o_wrdata_mark_col,
         o_wrdata_mark_matrix, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix,
         o_busy, o_done, o_given_cnt, o_error} !== 48'd0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b addr=%0d busy=%b done=%b cnt=%0d err=%b, all required 0",
               o_we, o_addr, o_busy, o_done, o_given_cnt, o_error);
    end
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
    total++;
    if (o_conflict_idx !== 7'd0) begin
      bad++;
      $display("FAIL reset_conflict_idx: got %0d required 0", o_conflict_idx);
    end
`endif
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({o_ready, o_busy, o_we} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got ready/busy/we=%b required 000", {o_ready, o_busy, o_we});
    end
  endtask

  task automatic test_clear();
    zero_grid();
    run_grid(1'b0, N);
    total++;
    if (wq.size() != 2 * N) begin
      bad++;
      $display("FAIL clear_write_count: got %0d required %0d", wq.size(), 2 * N);
    end else begin
      for (int k = 0; k < N; k++) begin
        total++;
        if (wq[k] !== exp_clear(k)) begin
          bad++;
          $display("FAIL clear_write[%0d]: got %h required %h", k, wq[k], exp_clear(k));
        end
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (wq[N + i] !== exp_load(i, 4'd0)) begin
          bad++;
          $display("FAIL zero_load_write[%0d]: got %h required %h", i, wq[N + i], exp_load(i, 4'd0));
        end
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL clear_done_pulses: got %0d required 1", done_cnt);
    end
    total++;
    if (busy_cnt != 2 * N) begin
      bad++;
      $display("FAIL clear_busy_cycles: got %0d required %0d", busy_cnt, 2 * N);
    end
    total++;
    if ({o_given_cnt, o_error, o_busy} !== 9'd0) begin
      bad++;
      $display("FAIL clear_status: got cnt=%0d err=%b busy=%b required 0/0/0", o_given_cnt, o_error, o_busy);
    end
  endtask

  task automatic test_single_given();
    zero_grid();
    grid[43] = 4'd5;
    run_grid(1'b0, N);
    total++;
    if (wq.size() != 2 * N) begin
      bad++;
      $display("FAIL single_write_count: got %0d required %0d", wq.size(), 2 * N);
    end else begin
      // row 4, col 7, box 5, digit 5 -> marks 40 / 67 / 49
      total++;
      if (wq[N + 43] !== {7'd43, 4'd5, 1'b1, 7'd40, 7'd67, 7'd49, 3'b111}) begin
        bad++;
        $display("FAIL single_given_write: got %h required %h", wq[N + 43],
                 {7'd43, 4'd5, 1'b1, 7'd40, 7'd67, 7'd49, 3'b111});
      end
      total++;
      if (wq[N + 42] !== {7'd42, 4'd0, 1'b0, 21'd0, 3'b000}) begin
        bad++;
        $display("FAIL single_neighbour_write: got %h required empty cell 42", wq[N + 42]);
      end
    end
    total++;
    if (o_given_cnt !== 7'd1) begin
      bad++;
      $display("FAIL single_given_cnt: got %0d required 1", o_given_cnt);
    end
  endtask

  task automatic test_backpressure();
    int r, c, exp_cnt;
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      r = i / 9;
      c = i % 9;
      grid[i] = (i % 4 == 1) ? 4'd0 : 4'(((r * 3 + r / 3 + c) % 9) + 1);
      if (grid[i] != 4'd0) exp_cnt++;
    end
    run_grid(1'b1, N);
    total++;
    if (wq.size() != 2 * N) begin
      bad++;
      $display("FAIL bp_write_count: got %0d required %0d", wq.size(), 2 * N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (wq[N + i] !== exp_load(i, grid[i])) begin
          bad++;
          $display("FAIL bp_write[%0d]: got %h required %h", i, wq[N + i], exp_load(i, grid[i]));
        end
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL bp_done_pulses: got %0d required 1", done_cnt);
    end
    total++;
    if (o_given_cnt !== 7'(exp_cnt) || o_error !== 1'b0) begin
      bad++;
      $display("FAIL bp_status: got cnt=%0d err=%b required cnt=%0d err=0", o_given_cnt, o_error, exp_cnt);
    end
  endtask

  task automatic test_bad_digit();
    zero_grid();
    grid[0] = 4'd12;
    run_grid(1'b0, N);
    total++;
    if (wq.size() != 2 * N) begin
      bad++;
      $display("FAIL bad_write_count: got %0d required %0d", wq.size(), 2 * N);
    end else begin
      total++;
      if (wq[N] !== '0) begin
        bad++;
        $display("FAIL bad_digit_write: got %h required all-zero write at idx 0", wq[N]);
      end
    end
    repeat (4) tick();
    total++;
    if (o_error !== 1'b1 || o_given_cnt !== 7'd0) begin
      bad++;
      $display("FAIL bad_digit_sticky: got err=%b cnt=%0d required err=1 cnt=0", o_error, o_given_cnt);
    end
    zero_grid();
    run_grid(1'b0, N);
    total++;
    if (o_error !== 1'b0) begin
      bad++;
      $display("FAIL bad_digit_cleared: got err=%b required 0 after new start", o_error);
    end
  endtask

  task automatic test_reset_mid_load();
    zero_grid();
    grid[30] = 4'd7;
    run_grid(1'b0, 30);
    rst     = 1'b1;
    i_valid = 1'b1;
    i_digit = grid[30];
    tick();
    total++;
    if ({o_ready, o_we, o_wrdata, o_addr, o_we_mark, o_wrdata_mark_row, o_wrdata_mark_col,
         o_wrdata_mark_matrix, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix,
         o_busy, o_done, o_given_cnt, o_error} !== 48'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got we=%b addr=%0d ready=%b busy=%b required all 0",
               o_we, o_addr, o_ready, o_busy);
    end
    rst     = 1'b0;
    i_valid = 1'b0;
    i_digit = 4'd0;
    tick();
    zero_grid();
    run_grid(1'b0, N);
    total++;
    if (wq.size() != 2 * N) begin
      bad++;
      $display("FAIL restart_write_count: got %0d required %0d", wq.size(), 2 * N);
    end else begin
      total++;
      if (wq[0] !== exp_clear(0) || wq[N - 1] !== exp_clear(N - 1)) begin
        bad++;
        $display("FAIL restart_clear: got first=%h last=%h required first=%h last=%h",
                 wq[0], wq[N - 1], exp_clear(0), exp_clear(N - 1));
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL restart_done_pulses: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_conflict();
    zero_grid();
    grid[0] = 4'd3;
    grid[8] = 4'd3;
    run_grid(1'b0, N);
    total++;
    if (o_given_cnt !== 7'd2) begin
      bad++;
      $display("FAIL conflict_given_cnt: got %0d required 2", o_given_cnt);
    end
    total++;
    if (wq.size() != 2 * N || wq[N + 8] !== exp_load(8, 4'd3)) begin
      bad++;
      $display("FAIL conflict_cell_write: got size=%0d write=%h required write=%h",
               wq.size(), wq[N + 8], exp_load(8, 4'd3));
    end
`ifdef SUDOKU_LOADER_CONFLICT_CHECK_EN
    total++;
    if (o_error !== 1'b1 || o_conflict_idx !== 7'd8) begin
      bad++;
      $display("FAIL conflict_flag: got err=%b idx=%0d required err=1 idx=8", o_error, o_conflict_idx);
    end
`else
    total++;
    if (o_error !== 1'b0) begin
      bad++;
      $display("FAIL conflict_no_check: got err=%b required 0", o_error);
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_single_given();
    test_backpressure();
    test_bad_digit();
    test_reset_mid_load();
    test_conflict();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sudoku_loader.md
Name: sudoku_loader

Overview:
- Upstream stage of the solver's grid memory.
- Clears the 81-cell grid and all row/col/matrix mark arrays, then accepts the puzzle as a raster-order stream of 81 cells over a valid/ready handshake.
- For each cell it writes the digit to the data array. For each given (non-zero) digit it also sets the row, col and matrix marks.
- Drives the memory's write-side ports directly; the solver FSM takes over the memory after o_done.

Parameters:
- N_CELL, 81, cells per grid. Fixed for 9x9; used for counter terminal values.
- MARK_STRIDE, 9, mark entries per row/col/matrix group. Mark address = group*9 + (digit-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- i_start  input  1  one-cycle pulse; starts clear+load. Honoured only in IDLE.
- i_valid  input  1  upstream cell digit valid.
- i_digit  input  4  cell digit: 0 = empty, 1-9 = given.
- o_ready  output  1  loader accepts i_digit this cycle.
- o_we  output  1  data-array write strobe to memory.
- o_wrdata  output  4  data-array write value.
- o_addr  output  7  data-array address, 0-80.
- o_we_mark  output  1  mark write strobe (row, col and matrix written together).
- o_wrdata_mark_row  output  1  row mark write value.
- o_wrdata_mark_col  output  1  col mark write value.
- o_wrdata_mark_matrix  output  1  matrix mark write value.
- o_addr_mark_row  output  7  row mark address.
- o_addr_mark_col  output  7  col mark address.
- o_addr_mark_matrix  output  7  matrix mark address.
- o_busy  output  1  high from the cycle after an accepted i_start until o_done.
- o_done  output  1  one-cycle pulse after the last write is issued.
- o_given_cnt  output  7  number of given digits loaded (0-81).
- o_error  output  1  sticky error flag; cleared by the next accepted i_start.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state = IDLE; all outputs 0; counters 0. Memory contents are not touched. Reset mid-operation aborts immediately; any partial grid is left as-is.
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - o_ready = 0.
  - i_start = 1 -> CLEAR, with k = 0, given_cnt = 0, error = 0.
  - i_start in any other state is ignored.
- CLEAR:
  - Runs exactly 81 cycles, k = 0..80.
  - Each cycle issues a registered write: o_we = 1, o_addr = k, o_wrdata = 0, o_we_mark = 1.
  - All three mark addresses = k; all mark data = 0.
  - After k = 80 -> LOAD, with row = col = 0.
- LOAD:
  - o_ready = 1 (combinational from state).
  - Beat accepted when i_valid & o_ready.
  - Cell idx = row*9 + col; box = (row/3)*3 + col/3.
  - On accept, next cycle: o_we = 1, o_addr = idx, o_wrdata = digit.
  - If digit is 1-9: o_we_mark = 1; o_addr_mark_row = row*9+d-1; o_addr_mark_col = col*9+d-1; o_addr_mark_matrix = box*9+d-1; all mark data = 1; given_cnt increments.
  - If digit = 0: o_we_mark = 0.
  - If digit is 10-15: o_wrdata = 0, o_we_mark = 0, o_error set.
  - col wraps 8 -> 0 and row increments. On accept of idx 80 -> DONE.
  - No accept -> o_we = o_we_mark = 0 the next cycle; counters hold.
- Latency: write strobes appear 1 cycle after the accept edge. All memory-facing outputs are registered.
- DONE:
  - o_done = 1 for one cycle, o_busy = 0, then -> IDLE.
  - The last write (idx 80) is on the bus in the DONE cycle.
- Addresses are computed at 7 bits; max mark address 8*9+8 = 80.
- Idle write outputs: all strobes 0. Addresses and data hold their last values.

Optional Feature:
- Macro: SUDOKU_LOADER_CONFLICT_CHECK_EN.
- Defined:
  - Keeps internal shadow bitmaps of 9 rows x 9, 9 cols x 9 and 9 boxes x 9 bits, cleared on accepted i_start.
  - On a given digit whose row, col or box bit is already set, o_error is set (sticky). The cell and its marks are still written.
  - o_conflict_idx (7-bit output, present only when the macro is defined) latches the first offending idx; reset value 0.
- Undefined: no bitmaps, no o_conflict_idx; o_error reflects only digits 10-15.

Test Plan:
- Clear phase: i_start, stream 81 zeros -> 81 consecutive CLEAR writes at addrs 0..80 with data/marks 0; then 81 data writes of 0 with o_we_mark = 0; o_given_cnt = 0; o_done pulse.
- Single given: cell (row 4, col 7) = 5, others 0 -> at idx 43: o_wrdata = 5, mark_row addr 40, mark_col addr 67, mark_matrix addr 49, data 1; o_given_cnt = 1.
- Back-pressure: i_valid toggled 1/0 randomly -> writes only after accepted beats; order and addresses unchanged; o_done exactly once after 81 accepts.
- Bad digit: cell idx 0 = 12 -> o_wrdata = 0, o_we_mark = 0, o_error = 1 until the next i_start.
- Reset mid-LOAD: rst at idx 30 -> next cycle all outputs 0, state IDLE; a fresh i_start restarts CLEAR from addr 0.
- Conflict (macro defined): digit 3 at idx 0 and idx 8 -> o_error = 1, o_conflict_idx = 8; o_given_cnt = 2. With the macro undefined -> o_error = 0.
